axi4_lite_initiator: RTL
========================

AXI4_LITE_INITIATOR -- requirements
Module: axi4_lite_initiator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- A, 16, address width in bits.
- N, 4, data width in bytes.
- TIMEOUT, 1024, cycles allowed per transaction before abort; minimum 2.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- aclk, in, 1, sole clock.
- aresetn, in, 1, synchronous active-low reset.
- axi4_m, axi4_if #(A,N) master side, -, AXI4-Lite initiator port.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command accepted when high with cmd_valid.
- cmd_write, in, 1, 1 means write, 0 means read.
- cmd_addr, in, A, byte address.
- cmd_wdata, in, 8N, write data.
- cmd_wstrb, in, N, write byte strobes.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed.
- rsp_rdata, out, 8N, read data; 0 for writes.
- rsp_resp, out, 2, AXI response code.
- rsp_timeout, out, 1, transaction aborted by timeout.
REQ-003 The block SHALL use one clock (aclk) with a synchronous, active-low reset (aresetn); the polarity and synchronicity are fixed.
REQ-004 The block SHALL drive awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready, araddr, arvalid, arprot and rready, and SHALL sample awready, wready, bvalid, bresp, arready, rvalid, rdata and rresp; awprot and arprot SHALL be 3'b000.

Function
REQ-005 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP and DRAIN.
REQ-006 cmd_ready SHALL be high only in IDLE; a handshake SHALL latch all cmd_* fields and go to WR_REQ if cmd_write is 1, otherwise to RD_REQ.
REQ-007 WR_REQ SHALL assert awvalid and wvalid from the cycle after acceptance; each SHALL drop independently the cycle after its own ready is sampled high; once both have completed, the FSM SHALL go to WR_RESP.
REQ-008 WR_RESP SHALL hold bready high; on bvalid it SHALL capture bresp, set rsp_rdata to 0 and go to RSP.
REQ-009 RD_REQ SHALL assert arvalid until arready, then go to RD_RESP; RD_RESP SHALL hold rready high and, on rvalid, capture rdata and rresp and go to RSP.
REQ-010 RSP SHALL hold rsp_valid and the response fields stable until rsp_ready, then return to IDLE.
REQ-011 With a zero-wait slave, write latency SHALL be 3 cycles from the command handshake to rsp_valid; read latency SHALL also be 3 cycles.
REQ-012 A valid signal, once asserted, SHALL never drop before its handshake, and its payload SHALL not change while it is pending.
REQ-013 The timeout counter SHALL clear on command acceptance and increment in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
REQ-014 When the counter reaches TIMEOUT-1, the FSM SHALL go to DRAIN and present a response with rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0.
REQ-015 DRAIN SHALL keep every pending valid asserted until its handshake, and SHALL hold bready or rready high until the late response arrives and is discarded.
REQ-016 DRAIN SHALL reach IDLE only after both the drain work and the rsp handshake are complete; cmd_ready SHALL stay 0 throughout DRAIN.
REQ-017 If the last expected response arrives in the same cycle as the timeout expires, the response SHALL win: the transaction completes normally and rsp_timeout stays 0.
REQ-018 Address and data SHALL pass through unmodified; there SHALL be no alignment check.

Reset
REQ-019 While aresetn is 0 at a clock edge, the state SHALL become IDLE, all valid and ready outputs SHALL become 0, rsp_* SHALL become 0, and the counter SHALL clear.
REQ-020 cmd_ready SHALL first be 1 on the first cycle after aresetn is sampled high.
REQ-021 A reset mid-transaction SHALL abandon the transaction with no response.

Structure
REQ-022 A package axi4_lite_initiator_pkg SHALL hold the state enum and the response constants OKAY=2'b00 and SLVERR=2'b10.
REQ-023 The block SHALL have no sub-module; all outputs SHALL come from flops or from the state decode.

Verification
REQ-024 The bench SHALL cover the following directed scenarios.
- Write 0x0010 / 0xDEADBEEF / strb 0xF to a zero-wait slave -> AW and W fire together, rsp_valid 3 cycles after the command handshake, rsp_resp=00.
- Read 0x0020 with the slave returning 0x12345678 after 5 wait cycles -> rsp_rdata=0x12345678, rsp_resp=00, rready held high through the wait.
- Write with awready 4 cycles late and wready immediate -> wvalid drops after 1 cycle, awvalid held with awaddr stable, a single B accepted.
- TIMEOUT=8 against a slave that never asserts bvalid -> at cycle 8 rsp_resp=10 and rsp_timeout=1; a bvalid at cycle 20 is absorbed; cmd_ready returns to 1 afterwards.
- rsp_ready held low for 10 cycles -> rsp fields stay stable and cmd_ready stays 0.
- aresetn pulsed low while in RD_RESP -> all outputs 0 the next cycle, and cmd_ready is 1 on the first cycle after release.

Source files
------------

// File: rtl/axi4_lite_initiator_pkg.sv
// Shared types and constants for the AXI4-Lite initiator: FSM state encoding and the response
// codes the initiator generates on its own.
package axi4_lite_initiator_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrReq  = 3'd1,
    StWrResp = 3'd2,
    StRdReq  = 3'd3,
    StRdResp = 3'd4,
    StRsp    = 3'd5,
    StDrain  = 3'd6
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi4_if.sv
// AXI4-Lite signal bundle with master and slave views.
interface axi4_if #(
  parameter int unsigned A = 16,
  parameter int unsigned N = 4
);

  logic [A-1:0]   awaddr;
  logic           awvalid;
  logic           awready;
  logic [2:0]     awprot;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           wvalid;
  logic           wready;
  logic           bvalid;
  logic           bready;
  logic [1:0]     bresp;
  logic [A-1:0]   araddr;
  logic           arvalid;
  logic           arready;
  logic [2:0]     arprot;
  logic           rvalid;
  logic           rready;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;

  modport master (
    output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    output araddr, arvalid, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    input  araddr, arvalid, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_initiator.sv
// Single-outstanding AXI4-Lite initiator: turns one cmd_* request into an AXI transaction and
// returns the result on rsp_*, aborting with SLVERR after TIMEOUT cycles.
module axi4_lite_initiator
  import axi4_lite_initiator_pkg::*;
#(
  parameter int unsigned A       = 16,
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           aclk,
  input  logic           aresetn,
  axi4_if.master         axi4_m,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  logic [A-1:0]   cmd_addr,
  input  logic [8*N-1:0] cmd_wdata,
  input  logic [N-1:0]   cmd_wstrb,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [8*N-1:0] rsp_rdata,
  output logic [1:0]     rsp_resp,
  output logic           rsp_timeout
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           write_q, write_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [8*N-1:0] wdata_q, wdata_d;
  logic [N-1:0]   wstrb_q, wstrb_d;
  logic           aw_pend_q, aw_pend_d;
  logic           w_pend_q, w_pend_d;
  logic           ar_pend_q, ar_pend_d;
  logic           drain_b_q, drain_b_d;
  logic           drain_r_q, drain_r_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [8*N-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]     rsp_resp_q, rsp_resp_d;
  logic           rsp_timeout_q, rsp_timeout_d;
  logic           expired;
  logic           abort;

  assign expired = (cnt_q == CntLast);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    abort         = 1'b0;
    // Pending channel and drain flags retire on their own handshakes in any state.
    aw_pend_d = aw_pend_q & ~axi4_m.awready;
    w_pend_d  = w_pend_q & ~axi4_m.wready;
    ar_pend_d = ar_pend_q & ~axi4_m.arready;
    drain_b_d = drain_b_q & ~axi4_m.bvalid;
    drain_r_d = drain_r_q & ~axi4_m.rvalid;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          cnt_d   = '0;
          if (cmd_write) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = StWrReq;
          end else begin
            ar_pend_d = 1'b1;
            state_d   = StRdReq;
          end
        end
      end
      StWrReq: begin
        cnt_d = cnt_q + CntW'(1);
        if (!aw_pend_d && !w_pend_d) state_d = StWrResp;
        if (expired) abort = 1'b1;
      end
      StWrResp: begin
        cnt_d = cnt_q + CntW'(1);
        // A response landing on the expiry cycle still completes normally.
        if (axi4_m.bvalid) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = axi4_m.bresp;
          rsp_timeout_d = 1'b0;
          state_d       = StRsp;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      StRdReq: begin
        cnt_d = cnt_q + CntW'(1);
        if (!ar_pend_d) state_d = StRdResp;
        if (expired) abort = 1'b1;
      end
      StRdResp: begin
        cnt_d = cnt_q + CntW'(1);
        if (axi4_m.rvalid) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = axi4_m.rdata;
          rsp_resp_d    = axi4_m.rresp;
          rsp_timeout_d = 1'b0;
          state_d       = StRsp;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StDrain: begin
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
        if (!rsp_valid_d && !aw_pend_d && !w_pend_d && !ar_pend_d && !drain_b_d && !drain_r_d) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Timed-out transaction: report now, keep absorbing the slave's outstanding work.
    if (abort) begin
      state_d       = StDrain;
      drain_b_d     = write_q;
      drain_r_d     = ~write_q;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = SLVERR;
      rsp_timeout_d = 1'b1;
    end

    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_pend_q     <= 1'b0;
      w_pend_q      <= 1'b0;
      ar_pend_q     <= 1'b0;
      drain_b_q     <= 1'b0;
      drain_r_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      aw_pend_q     <= aw_pend_d;
      w_pend_q      <= w_pend_d;
      ar_pend_q     <= ar_pend_d;
      drain_b_q     <= drain_b_d;
      drain_r_q     <= drain_r_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign axi4_m.awaddr  = addr_q;
  assign axi4_m.awvalid = aw_pend_q;
  assign axi4_m.awprot  = 3'b000;
  assign axi4_m.wdata   = wdata_q;
  assign axi4_m.wstrb   = wstrb_q;
  assign axi4_m.wvalid  = w_pend_q;
  assign axi4_m.bready  = (state_q == StWrResp) | drain_b_q;
  assign axi4_m.araddr  = addr_q;
  assign axi4_m.arvalid = ar_pend_q;
  assign axi4_m.arprot  = 3'b000;
  assign axi4_m.rready  = (state_q == StRdResp) | drain_r_q;

endmodule
